// File: rtl/proj_index_sequencer.sv
// Two-level (pass, index) address sequencer for walking the feature-map buffer
// once per MinHash permutation, with stall, abort and free-running restart.
module proj_index_sequencer #(
  parameter int IDX_W  = 8,
  parameter int PASS_W = 4
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  in_len,
  input  logic [PASS_W-1:0] in_passes,
  input  logic              in_continuous,
  input  logic              stall,
  input  logic              abort,
  output logic [IDX_W-1:0]  index,
  output logic [PASS_W-1:0] pass_idx,
  output logic              valid,
  output logic              last_in_pass,
  output logic              busy,
  output logic              finished_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   len_q, len_d;
  logic [PASS_W-1:0]  passes_q, passes_d;
  logic               cont_q, cont_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [PASS_W-1:0]  pass_q, pass_d;
  logic               fin_q, fin_d;
  logic               idx_end, pass_end;

  // Only meaningful in RUN, where len and passes are known to be non-zero.
  assign idx_end  = (index_q == (len_q - IDX_W'(1)));
  assign pass_end = (pass_q == (passes_q - PASS_W'(1)));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    passes_d = passes_q;
    cont_d   = cont_q;
    index_d  = index_q;
    pass_d   = pass_q;
    fin_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d    = in_len;
          passes_d = in_passes;
          cont_d   = in_continuous;
          index_d  = '0;
          pass_d   = '0;
          if ((in_len == '0) || (in_passes == '0)) begin
            state_d = S_DONE;
            fin_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          index_d = '0;
          pass_d  = '0;
        end else if (!stall) begin
          if (!idx_end) begin
            index_d = index_q + IDX_W'(1);
          end else if (!pass_end) begin
            index_d = '0;
            pass_d  = pass_q + PASS_W'(1);
          end else begin
            // Sequence end: continuous mode wraps in place and pulses next cycle.
            index_d = '0;
            pass_d  = '0;
            fin_d   = 1'b1;
            if (!cont_q) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        index_d = '0;
        pass_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        index_d = '0;
        pass_d  = '0;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      passes_q <= '0;
      cont_q   <= 1'b0;
      index_q  <= '0;
      pass_q   <= '0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      passes_q <= passes_d;
      cont_q   <= cont_d;
      index_q  <= index_d;
      pass_q   <= pass_d;
      fin_q    <= fin_d;
    end
  end

  assign index          = index_q;
  assign pass_idx       = pass_q;
  assign valid          = (state_q == S_RUN) && !stall;
  assign last_in_pass   = valid && idx_end;
  assign busy           = (state_q != S_IDLE);
  assign finished_count = fin_q;

endmodule

// File: tb/tb_proj_index_sequencer.sv
// Directed scoreboard bench for proj_index_sequencer: expected per-cycle outputs
// are queued as stimulus is planned and popped at each falling edge.
module tb_proj_index_sequencer;

  localparam int IDX_W  = 8;
  localparam int PASS_W = 4;

  logic              clk = 1'b0;
  logic              rst, start, cont, stall, abort;
  logic [IDX_W-1:0]  len;
  logic [PASS_W-1:0] passes;
  logic [IDX_W-1:0]  index;
  logic [PASS_W-1:0] pass_idx;
  logic              valid, last_in_pass, busy, finished_count;

  typedef struct {
    string             tag;
    logic [IDX_W-1:0]  idx;
    logic [PASS_W-1:0] pas;
    logic              v, l, b, f;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  proj_index_sequencer #(.IDX_W(IDX_W), .PASS_W(PASS_W)) dut (
    .in_clk         (clk),
    .in_rst         (rst),
    .start          (start),
    .in_len         (len),
    .in_passes      (passes),
    .in_continuous  (cont),
    .stall          (stall),
    .abort          (abort),
    .index          (index),
    .pass_idx       (pass_idx),
    .valid          (valid),
    .last_in_pass   (last_in_pass),
    .busy           (busy),
    .finished_count (finished_count)
  );

  task automatic push(input string tag, input int i, input int p,
                      input logic v, input logic l, input logic b, input logic f);
    exp_t e;
    e.tag = tag;
    e.idx = i[IDX_W-1:0];
    e.pas = p[PASS_W-1:0];
    e.v = v; e.l = l; e.b = b; e.f = f;
    sbq.push_back(e);
  endtask

  task automatic push_idle(input string tag, input int n);
    for (int k = 0; k < n; k++) push(tag, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Inputs are set just after a rising edge; outputs are checked at the falling edge.
  task automatic run(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $error("FAIL underflow: observed output with no expected entry");
      end else begin
        e = sbq.pop_front();
        assert ({index, pass_idx, valid, last_in_pass, busy, finished_count} ===
                {e.idx, e.pas, e.v, e.l, e.b, e.f})
        else begin
          errors++;
          $error("FAIL %s: got idx=%0d pass=%0d v=%b last=%b busy=%b fin=%b, expected idx=%0d pass=%0d v=%b last=%b busy=%b fin=%b",
                 e.tag, index, pass_idx, valid, last_in_pass, busy, finished_count,
                 e.idx, e.pas, e.v, e.l, e.b, e.f);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; stall = 1'b0; abort = 1'b0;
    len = '0; passes = '0;
    @(posedge clk); #1;

    // 1. reset state, then basic 4 x 2 run
    push_idle("reset", 1); run(1);
    rst = 1'b0;
    start = 1'b1; len = 8'd4; passes = 4'd2; cont = 1'b0;
    push_idle("t1_start", 1); run(1);
    start = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) push("t1_run", i, p, 1'b1, i == 3, 1'b1, 1'b0);
    run(8);
    start = 1'b1;  // ignored in DONE
    push("t1_done", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1); run(1);
    start = 1'b0;
    push_idle("t1_idle", 2); run(2);

    // 2. stall for two cycles at index 1
    start = 1'b1; len = 8'd3; passes = 4'd1;
    push_idle("t2_start", 1); run(1);
    start = 1'b0;
    push("t2_run", 0, 0, 1'b1, 1'b0, 1'b1, 1'b0); run(1);
    stall = 1'b1;
    push("t2_stall", 1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    push("t2_stall", 1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    run(2);
    stall = 1'b0;
    push("t2_resume", 1, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    push("t2_resume", 2, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    push("t2_done", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    push_idle("t2_idle", 1);
    run(4);

    // 3. abort at pass 1 index 5, then start/config changes while busy
    start = 1'b1; len = 8'd8; passes = 4'd3;
    push_idle("t3_start", 1); run(1);
    start = 1'b0;
    for (int i = 0; i < 8; i++) push("t3_p0", i, 0, 1'b1, i == 7, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) push("t3_p1", i, 1, 1'b1, 1'b0, 1'b1, 1'b0);
    run(13);
    abort = 1'b1;
    push("t3_abort", 5, 1, 1'b1, 1'b0, 1'b1, 1'b0); run(1);
    abort = 1'b0;
    push_idle("t3_post_abort", 2); run(2);
    start = 1'b1; len = 8'd3; passes = 4'd1; cont = 1'b0;
    push_idle("t3b_start", 1); run(1);
    len = 8'd7; passes = 4'd5; cont = 1'b1;  // start held high, config changed while busy
    for (int i = 0; i < 3; i++) push("t3b_run", i, 0, 1'b1, i == 2, 1'b1, 1'b0);
    push("t3b_done", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    run(4);
    start = 1'b0;
    push_idle("t3b_idle", 2); run(2);

    // 4. continuous 2 x 2 for three sequences, abort on the fourth's first cycle
    start = 1'b1; len = 8'd2; passes = 4'd2; cont = 1'b1;
    push_idle("t4_start", 1); run(1);
    start = 1'b0;
    for (int s = 0; s < 3; s++)
      for (int p = 0; p < 2; p++)
        for (int i = 0; i < 2; i++)
          push("t4_run", i, p, 1'b1, i == 1, 1'b1, (s > 0) && (p == 0) && (i == 0));
    run(12);
    abort = 1'b1;
    push("t4_abort", 0, 0, 1'b1, 1'b0, 1'b1, 1'b1); run(1);
    abort = 1'b0;
    push_idle("t4_post_abort", 2); run(2);
    // abort on the wrap edge suppresses the pending pulse
    start = 1'b1; len = 8'd1; passes = 4'd1; cont = 1'b1;
    push_idle("t4b_start", 1); run(1);
    start = 1'b0;
    push("t4b_first", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0); run(1);
    abort = 1'b1;
    push("t4b_abort", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1); run(1);
    abort = 1'b0; cont = 1'b0;
    push_idle("t4b_post_abort", 2); run(2);

    // 5. degenerate lengths, then maximum length
    start = 1'b1; len = 8'd0; passes = 4'd3;
    push_idle("t5_len0_start", 1); run(1);
    start = 1'b0;
    push("t5_len0_done", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    push_idle("t5_len0_idle", 1);
    run(2);
    start = 1'b1; len = 8'd5; passes = 4'd0;
    push_idle("t5_pass0_start", 1); run(1);
    start = 1'b0;
    push("t5_pass0_done", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    push_idle("t5_pass0_idle", 1);
    run(2);
    start = 1'b1; len = 8'd255; passes = 4'd15;
    push_idle("t5_max_start", 1); run(1);
    start = 1'b0;
    for (int p = 0; p < 15; p++)
      for (int i = 0; i < 255; i++) push("t5_max", i, p, 1'b1, i == 254, 1'b1, 1'b0);
    push("t5_max_done", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    push_idle("t5_max_idle", 1);
    run(3827);

    // 6. reset mid-run
    start = 1'b1; len = 8'd16; passes = 4'd1;
    push_idle("t6_start", 1); run(1);
    start = 1'b0;
    for (int i = 0; i < 5; i++) push("t6_run", i, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    run(5);
    rst = 1'b1;
    push("t6_rst_cycle", 5, 0, 1'b1, 1'b0, 1'b1, 1'b0); run(1);
    rst = 1'b0;
    push_idle("t6_post_rst", 3); run(3);

    checks++;
    assert (sbq.size() === 0)
    else begin
      errors++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
